battle_ctrl: RTL and testbench

Parametrised game-flow controller for the two-player factorisation battle. It sequences READY → QUESTION → INPUT → result display, and owns both players' HP counters, round count and per-question wrong-answer budget. It consumes pre-decoded answer results rather than raw HP/judge flags. It sits between the input/judge logic and the display/HP drivers, which decode STATE, HP_P, HP_O and ROUND.

---
 rtl/battle_pkg.sv | 27 ++
 rtl/battle_ctrl_tick.sv | 29 ++
 rtl/battle_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_battle_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/battle_pkg.sv
// battle_pkg: state codes, result codes and state typedef shared by
// battle_ctrl and the display decoder.
package battle_pkg;

    typedef enum logic [3:0] {
        ST_READY    = 4'b0010,
        ST_QUESTION = 4'b0011,
        ST_INPUT    = 4'b0100,
        ST_DRAW     = 4'b0110,
        ST_WRONG    = 4'b0111,
        ST_GOOD     = 4'b1000,
        ST_OUCH     = 4'b1001,
        ST_WIN      = 4'b1010,
        ST_LOSE     = 4'b1011
    } state_e;

    localparam logic [2:0] RES_WRONG = 3'b001;
    localparam logic [2:0] RES_HIT   = 3'b010;
    localparam logic [2:0] RES_OUCH  = 3'b011;
    localparam logic [2:0] RES_DRAW  = 3'b100;

    function automatic logic is_hold(input state_e s);
        return s inside {ST_DRAW, ST_WRONG, ST_GOOD,
                         ST_OUCH, ST_WIN, ST_LOSE};
    endfunction

endpackage

// File: rtl/battle_ctrl_tick.sv
// tick_counter: counts enabled cycles from 0; done_o pulses on the
// cycle the count is TERM-1 and the counter wraps to 0 on that edge.
// Ports: clk_i, rst_ni (async low), clr_i, en_i -> done_o.
module tick_counter #(
    parameter int TERM = 8,
    parameter int W    = $clog2(TERM + 1)
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic done_o
);

    logic [W-1:0] cnt_q;

    assign done_o = en_i && (cnt_q == W'(TERM - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i || done_o) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/battle_ctrl.sv
// battle_ctrl: game-flow FSM for the factorisation battle; owns HP,
// round count and the per-question wrong-answer budget.
// Ports: CLK, RST (async low), START, Q_VALID, BOUT, RES_VALID, RES
//   -> STATE, HP_P, HP_O, ROUND, HOLD_ACT.
// Option: define BATTLE_TIMEOUT_EN to build the INPUT answer timeout.
module battle_ctrl
    import battle_pkg::*;
#(
    parameter int HP_W           = 4,
    parameter int HP_INIT        = 10,
    parameter int DMG            = 2,
    parameter int HOLD_CYCLES    = 8,
    parameter int MAX_WRONG      = 3,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int RND_W          = 6
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             Q_VALID,
    input  logic             BOUT,
    input  logic             RES_VALID,
    input  logic [2:0]       RES,
    output logic [3:0]       STATE,
    output logic [HP_W-1:0]  HP_P,
    output logic [HP_W-1:0]  HP_O,
    output logic [RND_W-1:0] ROUND,
    output logic             HOLD_ACT
);

    localparam int WC_W = $clog2(MAX_WRONG + 1);
    localparam logic [HP_W-1:0] HP_RST = HP_W'(HP_INIT);

    state_e           state_q, state_d;
    logic [HP_W-1:0]  hp_p_q, hp_p_d;
    logic [HP_W-1:0]  hp_o_q, hp_o_d;
    logic [RND_W-1:0] round_q, round_d;
    logic [WC_W-1:0]  wrong_q, wrong_d;
    logic             hold_act_q;
    logic             hold_done;
    logic             tmo_done;
    logic             in_hold;

    function automatic logic [HP_W-1:0] sub_sat(
        input logic [HP_W-1:0] hp
    );
        if (int'(hp) > DMG) return hp - HP_W'(DMG);
        return '0;
    endfunction

    assign in_hold = is_hold(state_q);

    // The counter wraps on done, so chained holds (GOOD->WIN)
    // also start from 0.
    tick_counter #(.TERM(HOLD_CYCLES)) u_hold (
        .clk_i (CLK),
        .rst_ni(RST),
        .clr_i (!in_hold),
        .en_i  (in_hold),
        .done_o(hold_done)
    );

`ifdef BATTLE_TIMEOUT_EN
    tick_counter #(.TERM(TIMEOUT_CYCLES)) u_tmo (
        .clk_i (CLK),
        .rst_ni(RST),
        .clr_i (state_q != ST_INPUT),
        .en_i  (state_q == ST_INPUT),
        .done_o(tmo_done)
    );
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
    assign tmo_done   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        hp_p_d  = hp_p_q;
        hp_o_d  = hp_o_q;
        round_d = round_q;
        wrong_d = wrong_q;

        unique case (state_q)
            ST_READY: begin
                if (START && Q_VALID) begin
                    state_d = ST_QUESTION;
                    wrong_d = '0;
                end
            end
            ST_QUESTION: begin
                if (BOUT && Q_VALID) begin
                    state_d = ST_INPUT;
                end else if (RES_VALID && RES == RES_OUCH) begin
                    state_d = ST_OUCH;
                end
            end
            ST_INPUT: begin
                if (!BOUT && Q_VALID) begin
                    state_d = ST_QUESTION;
                end else if (RES_VALID) begin
                    case (RES)
                        RES_WRONG: begin
                            // Budget spent: force the penalty.
                            if (int'(wrong_q) + 1 >= MAX_WRONG) begin
                                state_d = ST_OUCH;
                                wrong_d = '0;
                            end else begin
                                state_d = ST_WRONG;
                                wrong_d = wrong_q + 1'b1;
                            end
                        end
                        RES_HIT:  state_d = ST_GOOD;
                        RES_OUCH: state_d = ST_OUCH;
                        RES_DRAW: state_d = ST_DRAW;
                        default:  state_d = state_q;
                    endcase
                end else if (tmo_done) begin
                    state_d = ST_OUCH;
                end
            end
            ST_WRONG: begin
                if (hold_done) state_d = ST_INPUT;
            end
            ST_GOOD: begin
                if (hold_done) begin
                    state_d = (hp_o_q == '0) ? ST_WIN : ST_READY;
                end
            end
            ST_OUCH: begin
                if (hold_done) begin
                    state_d = (hp_p_q == '0) ? ST_LOSE : ST_READY;
                end
            end
            ST_DRAW: begin
                if (hold_done) begin
                    state_d = ST_READY;
                    if (hp_p_q == '0 && hp_o_q == '0) begin
                        hp_p_d  = HP_RST;
                        hp_o_d  = HP_RST;
                        round_d = '0;
                    end
                end
            end
            ST_WIN, ST_LOSE: begin
                if (hold_done) begin
                    state_d = ST_READY;
                    hp_p_d  = HP_RST;
                    hp_o_d  = HP_RST;
                    round_d = '0;
                end
            end
            default: state_d = ST_READY;
        endcase

        // Damage lands on the entry edge; these states are never
        // re-entered from themselves.
        if (state_d != state_q) begin
            case (state_d)
                ST_GOOD: begin
                    hp_o_d  = sub_sat(hp_o_q);
                    round_d = round_q + 1'b1;
                end
                ST_OUCH: begin
                    hp_p_d  = sub_sat(hp_p_q);
                    round_d = round_q + 1'b1;
                end
                ST_DRAW: begin
                    hp_p_d  = sub_sat(hp_p_q);
                    hp_o_d  = sub_sat(hp_o_q);
                    round_d = round_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_READY;
            hp_p_q     <= HP_RST;
            hp_o_q     <= HP_RST;
            round_q    <= '0;
            wrong_q    <= '0;
            hold_act_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hp_p_q     <= hp_p_d;
            hp_o_q     <= hp_o_d;
            round_q    <= round_d;
            wrong_q    <= wrong_d;
            hold_act_q <= is_hold(state_d);
        end
    end

    assign STATE    = state_q;
    assign HP_P     = hp_p_q;
    assign HP_O     = hp_o_q;
    assign ROUND    = round_q;
    assign HOLD_ACT = hold_act_q;

endmodule

// File: tb/tb_battle_ctrl.sv
// tb_battle_ctrl: directed self-checking bench for battle_ctrl
// (default parameters; timeout checks only with BATTLE_TIMEOUT_EN).
module tb_battle_ctrl;

    localparam int S_READY = 2;
    localparam int S_QUES  = 3;
    localparam int S_INPUT = 4;
    localparam int S_DRAW  = 6;
    localparam int S_WRONG = 7;
    localparam int S_GOOD  = 8;
    localparam int S_OUCH  = 9;
    localparam int S_WIN   = 10;
    localparam int S_LOSE  = 11;

    logic       CLK = 1'b0;
    logic       RST;
    logic       START, Q_VALID, BOUT, RES_VALID;
    logic [2:0] RES;
    logic [3:0] STATE;
    logic [3:0] HP_P, HP_O;
    logic [5:0] ROUND;
    logic       HOLD_ACT;

    int checks   = 0;
    int failures = 0;

    battle_ctrl dut (
        .CLK      (CLK),
        .RST      (RST),
        .START    (START),
        .Q_VALID  (Q_VALID),
        .BOUT     (BOUT),
        .RES_VALID(RES_VALID),
        .RES      (RES),
        .STATE    (STATE),
        .HP_P     (HP_P),
        .HP_O     (HP_O),
        .ROUND    (ROUND),
        .HOLD_ACT (HOLD_ACT)
    );

    always #5 CLK = ~CLK;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic check(input string tag, input int got,
                         input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic pulse(input logic [2:0] r);
        RES       = r;
        RES_VALID = 1'b1;
        tick(1);
        RES_VALID = 1'b0;
        RES       = 3'b000;
    endtask

    task automatic go_input();
        START   = 1'b1;
        Q_VALID = 1'b1;
        BOUT    = 1'b1;
        tick(1);
        check("to_question", int'(STATE), S_QUES);
        START = 1'b0;
        tick(1);
        check("to_input", int'(STATE), S_INPUT);
    endtask

    initial begin
        RST       = 1'b0;
        START     = 1'b0;
        Q_VALID   = 1'b0;
        BOUT      = 1'b0;
        RES_VALID = 1'b0;
        RES       = 3'b000;
        tick(2);
        check("rst_state", int'(STATE), S_READY);
        check("rst_hp_p", int'(HP_P), 10);
        check("rst_hp_o", int'(HP_O), 10);
        check("rst_round", int'(ROUND), 0);
        check("rst_hold", int'(HOLD_ACT), 0);
        RST = 1'b1;
        tick(1);
        check("idle_ready", int'(STATE), S_READY);

        // Normal hit, with an ignored pulse during the hold
        go_input();
        pulse(3'b010);
        check("hit_state", int'(STATE), S_GOOD);
        check("hit_hp_o", int'(HP_O), 8);
        check("hit_round", int'(ROUND), 1);
        check("hit_hold", int'(HOLD_ACT), 1);
        tick(2);
        pulse(3'b011);
        tick(4);
        check("hit_still", int'(STATE), S_GOOD);
        check("hit_ign_hp_p", int'(HP_P), 10);
        tick(1);
        check("hit_ready", int'(STATE), S_READY);
        check("hit_hold_off", int'(HOLD_ACT), 0);

        // Wrong budget: third wrong forces OUCH
        go_input();
        for (int i = 0; i < 2; i++) begin
            pulse(3'b001);
            check("wr_state", int'(STATE), S_WRONG);
            check("wr_hp_p", int'(HP_P), 10);
            tick(7);
            check("wr_still", int'(STATE), S_WRONG);
            tick(1);
            check("wr_back", int'(STATE), S_INPUT);
        end
        pulse(3'b001);
        check("wr3_state", int'(STATE), S_OUCH);
        check("wr3_hp_p", int'(HP_P), 8);
        check("wr3_round", int'(ROUND), 2);
        tick(8);
        check("wr3_ready", int'(STATE), S_READY);

        // QUESTION: only OUCH acts
        START   = 1'b1;
        Q_VALID = 1'b1;
        BOUT    = 1'b0;
        tick(1);
        check("q_state", int'(STATE), S_QUES);
        START = 1'b0;
        pulse(3'b010);
        check("q_hit_ign", int'(STATE), S_QUES);
        pulse(3'b011);
        check("q_ouch", int'(STATE), S_OUCH);
        check("q_hp_p", int'(HP_P), 6);
        check("q_round", int'(ROUND), 3);
        tick(8);
        check("q_ready", int'(STATE), S_READY);

        // INPUT -> QUESTION -> INPUT, then hit
        go_input();
        BOUT = 1'b0;
        tick(1);
        check("iq_back", int'(STATE), S_QUES);
        BOUT = 1'b1;
        tick(1);
        check("iq_input", int'(STATE), S_INPUT);
        pulse(3'b010);
        check("iq_hp_o", int'(HP_O), 6);
        tick(8);

        // Win path
        for (int k = 1; k <= 2; k++) begin
            go_input();
            pulse(3'b010);
            check("w_hp_o", int'(HP_O), 6 - 2 * k);
            tick(8);
            check("w_ready", int'(STATE), S_READY);
        end
        go_input();
        pulse(3'b010);
        check("win_good", int'(STATE), S_GOOD);
        check("win_hp_o", int'(HP_O), 0);
        check("win_round", int'(ROUND), 7);
        tick(8);
        check("win_state", int'(STATE), S_WIN);
        check("win_hold", int'(HOLD_ACT), 1);
        tick(7);
        check("win_still", int'(STATE), S_WIN);
        tick(1);
        check("win_ready", int'(STATE), S_READY);
        check("win_hp_p", int'(HP_P), 10);
        check("win_hp_o2", int'(HP_O), 10);
        check("win_rnd0", int'(ROUND), 0);

        // Double KO via five draws
        for (int k = 1; k <= 5; k++) begin
            go_input();
            pulse(3'b100);
            check("dr_state", int'(STATE), S_DRAW);
            check("dr_hp_p", int'(HP_P), 10 - 2 * k);
            check("dr_hp_o", int'(HP_O), 10 - 2 * k);
            check("dr_round", int'(ROUND), k);
            tick(8);
            check("dr_ready", int'(STATE), S_READY);
            if (k == 5) begin
                check("ko_hp_p", int'(HP_P), 10);
                check("ko_hp_o", int'(HP_O), 10);
                check("ko_round", int'(ROUND), 0);
            end
        end

        // Back-to-back RES_VALID: second pulse ignored
        go_input();
        RES       = 3'b010;
        RES_VALID = 1'b1;
        tick(2);
        RES_VALID = 1'b0;
        check("b2b_state", int'(STATE), S_GOOD);
        check("b2b_hp_o", int'(HP_O), 8);
        check("b2b_round", int'(ROUND), 1);
        tick(6);
        check("b2b_still", int'(STATE), S_GOOD);
        tick(1);
        check("b2b_ready", int'(STATE), S_READY);

        // Lose path
        for (int k = 1; k <= 5; k++) begin
            go_input();
            pulse(3'b011);
            check("lo_hp_p", int'(HP_P), 10 - 2 * k);
            check("lo_round", int'(ROUND), 1 + k);
            tick(8);
            check("lo_next", int'(STATE), (k < 5) ? S_READY : S_LOSE);
        end
        tick(8);
        check("lose_ready", int'(STATE), S_READY);
        check("lose_hp_p", int'(HP_P), 10);
        check("lose_round", int'(ROUND), 0);

        // Async reset mid-GOOD
        go_input();
        pulse(3'b010);
        check("ar_good", int'(STATE), S_GOOD);
        tick(3);
        RST = 1'b0;
        #1;
        check("ar_state", int'(STATE), S_READY);
        check("ar_hp_o", int'(HP_O), 10);
        check("ar_round", int'(ROUND), 0);
        check("ar_hold", int'(HOLD_ACT), 0);
        tick(1);
        RST = 1'b1;
        tick(1);
        check("ar_ready", int'(STATE), S_READY);

        go_input();
`ifdef BATTLE_TIMEOUT_EN
        tick(63);
        check("to_wait", int'(STATE), S_INPUT);
        tick(1);
        check("to_ouch", int'(STATE), S_OUCH);
        check("to_hp_p", int'(HP_P), 8);
        tick(8);
        go_input();
        tick(63);
        RES       = 3'b010;
        RES_VALID = 1'b1;
        tick(1);
        RES_VALID = 1'b0;
        check("to_prio", int'(STATE), S_GOOD);
        check("to_prio_hp_o", int'(HP_O), 8);
`else
        tick(100);
        check("no_timeout", int'(STATE), S_INPUT);
        check("no_to_hp_p", int'(HP_P), 10);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
